// File: rtl/sqsum_feed.sv
// sqsum_feed: forms I*I + Q*Q from a signed I/Q sample and hands it to a
// 32-bit square-root core with a valid/done handshake. Per operation:
// IDLE -> MUL -> ADD -> HOLD -> GAP -> IDLE.
// Optional feature macro: SQSUM_FEED_FIFO_EN adds a 2-entry input FIFO
// ahead of the FSM so the upstream can queue samples while the core is busy.
module sqsum_feed #(
  parameter int IN_W    = 16,
  parameter int TIMEOUT = 40
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [IN_W-1:0] in_i,
  input  logic [IN_W-1:0] in_q,
  output logic            sq_vld,
  output logic [31:0]     sq_x,
  input  logic            sq_done,
  output logic            err,
  output logic [15:0]     ops_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_ADD  = 3'd2,
    S_HOLD = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  localparam int         PW        = 2 * IN_W;
  // The wait counter is compared against TIMEOUT-1 so the timeout edge
  // lands exactly TIMEOUT cycles after HOLD entry.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic            in_rdy_q, in_rdy_d;
  logic [IN_W-1:0] op_i_q, op_q_q;
  logic [PW-1:0]   prod_i_q, prod_q_q;
  logic [PW-1:0]   ext_i_s, ext_q_s;
  logic [31:0]     sq_x_q;
  logic            sq_vld_q;
  logic            err_q;
  logic [15:0]     ops_q;
  logic [7:0]      wait_q;
  logic            start_s;
  logic            timeout_s;
  logic [IN_W-1:0] src_i_s, src_q_s;

`ifdef SQSUM_FEED_FIFO_EN
  logic [PW-1:0] fifo_mem_q [2];
  logic          fifo_wp_q, fifo_rp_q;
  logic [1:0]    fifo_cnt_q, fifo_cnt_d;
  logic          push_s, pop_s;

  assign push_s  = in_vld & in_rdy_q;
  assign pop_s   = (state_q == S_IDLE) & (fifo_cnt_q != 2'd0);
  assign start_s = pop_s;
  assign src_i_s = fifo_mem_q[fifo_rp_q][PW-1:IN_W];
  assign src_q_s = fifo_mem_q[fifo_rp_q][IN_W-1:0];

  // FIFO occupancy next-state; ready means "not full" after this edge.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push_s && !pop_s) begin
      fifo_cnt_d = fifo_cnt_q + 2'd1;
    end else if (pop_s && !push_s) begin
      fifo_cnt_d = fifo_cnt_q - 2'd1;
    end else begin
      fifo_cnt_d = fifo_cnt_q;
    end
    in_rdy_d = (fifo_cnt_d != 2'd2);
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem_q[0] <= {PW{1'b0}};
      fifo_mem_q[1] <= {PW{1'b0}};
      fifo_wp_q     <= 1'b0;
      fifo_rp_q     <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_mem_q[fifo_wp_q] <= {in_i, in_q};
        fifo_wp_q             <= ~fifo_wp_q;
      end
      if (pop_s) begin
        fifo_rp_q <= ~fifo_rp_q;
      end
      fifo_cnt_q <= fifo_cnt_d;
    end
  end
`else
  assign start_s = in_vld & in_rdy_q & (state_q == S_IDLE);
  assign src_i_s = in_i;
  assign src_q_s = in_q;

  // Without a FIFO the block is ready exactly when the FSM will sit in IDLE.
  always_comb begin
    in_rdy_d = (state_d == S_IDLE);
  end
`endif

  assign timeout_s = (wait_q == WAIT_LAST);
  assign ext_i_s   = PW'($signed(op_i_q));
  assign ext_q_s   = PW'($signed(op_q_q));

  // FSM next-state: sq_done takes priority over a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          state_d = S_MUL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL:  state_d = S_ADD;
      S_ADD:  state_d = S_HOLD;
      S_HOLD: begin
        if (sq_done || timeout_s) begin
          state_d = S_GAP;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_GAP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, ready and operand-valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      in_rdy_q <= 1'b0;
      sq_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_rdy_q <= in_rdy_d;
      sq_vld_q <= (state_d == S_HOLD);
    end
  end

  // Datapath: capture sample, square both rails, then sum into the operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_i_q   <= {IN_W{1'b0}};
      op_q_q   <= {IN_W{1'b0}};
      prod_i_q <= {PW{1'b0}};
      prod_q_q <= {PW{1'b0}};
      sq_x_q   <= 32'd0;
    end else begin
      if (start_s) begin
        op_i_q <= src_i_s;
        op_q_q <= src_q_s;
      end
      if (state_q == S_MUL) begin
        prod_i_q <= ext_i_s * ext_i_s;
        prod_q_q <= ext_q_s * ext_q_s;
      end
      if (state_q == S_ADD) begin
        sq_x_q <= 32'(prod_i_q) + 32'(prod_q_q);
      end
    end
  end

  // HOLD wait counter, timeout error pulse and completed-operation count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= 8'd0;
      err_q  <= 1'b0;
      ops_q  <= 16'd0;
    end else begin
      if (state_q == S_HOLD) begin
        wait_q <= wait_q + 8'd1;
      end else begin
        wait_q <= 8'd0;
      end
      err_q <= (state_q == S_HOLD) & ~sq_done & timeout_s;
      if ((state_q == S_HOLD) && sq_done) begin
        ops_q <= ops_q + 16'd1;
      end
    end
  end

  assign in_rdy  = in_rdy_q;
  assign sq_vld  = sq_vld_q;
  assign sq_x    = sq_x_q;
  assign err     = err_q;
  assign ops_cnt = ops_q;

endmodule

// File: tb/tb_sqsum_feed.sv
// Self-checking bench for sqsum_feed (default build, no input FIFO).
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_sqsum_feed;

  localparam int IN_W    = 16;
  localparam int TIMEOUT = 40;

  logic            clk     = 1'b0;
  logic            rst_n   = 1'b0;
  logic            in_vld  = 1'b0;
  logic            sq_done = 1'b0;
  logic [IN_W-1:0] in_i    = 16'd0;
  logic [IN_W-1:0] in_q    = 16'd0;
  logic            in_rdy;
  logic            sq_vld;
  logic            err;
  logic [31:0]     sq_x;
  logic [15:0]     ops_cnt;

  int          errors  = 0;
  int          checks  = 0;
  logic [15:0] exp_ops = 16'd0;

  always #5 clk = ~clk;

  sqsum_feed #(.IN_W(IN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_i(in_i), .in_q(in_q), .sq_vld(sq_vld), .sq_x(sq_x),
    .sq_done(sq_done), .err(err), .ops_cnt(ops_cnt)
  );

  // Reference: magnitude squared with plain wide integer arithmetic.
  function automatic logic [31:0] model_sq(input int i, input int q);
    longint s;
    s = longint'(i) * longint'(i) + longint'(q) * longint'(q);
    return s[31:0];
  endfunction

  function automatic int rand_s16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_vld = 1'b0; sq_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_rdy !== 1'b0 || sq_vld !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: in_rdy/sq_vld/err=%b%b%b want 000", in_rdy, sq_vld, err);
    end
    checks++;
    if (sq_x !== 32'd0 || ops_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_data: sq_x=%h ops_cnt=%0d want 0 0", sq_x, ops_cnt);
    end
    rst_n = 1'b1;
    checks++;
    if (in_rdy !== 1'b0) begin
      errors++; $display("FAIL reset_rdy_early: in_rdy=%b want 0", in_rdy);
    end
    @(negedge clk);
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++; $display("FAIL reset_rdy_rise: in_rdy=%b want 1", in_rdy);
    end
    exp_ops = 16'd0;
  endtask

  task automatic test_basic();
    in_i = 16'd3; in_q = 16'd4; in_vld = 1'b1;
    @(negedge clk);   // accepted at edge N
    in_vld = 1'b0; in_i = 16'hdead; in_q = 16'hbeef;
    checks++;
    if (in_rdy !== 1'b0 || sq_vld !== 1'b0) begin
      errors++; $display("FAIL basic_busy: in_rdy=%b sq_vld=%b want 0 0", in_rdy, sq_vld);
    end
    @(negedge clk);
    checks++;
    if (sq_vld !== 1'b0) begin
      errors++; $display("FAIL basic_early_vld: sq_vld=%b want 0", sq_vld);
    end
    @(negedge clk);   // seen by edge N+3
    checks++;
    if (sq_vld !== 1'b1 || sq_x !== 32'd25) begin
      errors++; $display("FAIL basic_result: sq_vld=%b sq_x=%0d want 1 25", sq_vld, sq_x);
    end
    sq_done = 1'b1;
    @(negedge clk);
    sq_done = 1'b0; exp_ops++;
    checks++;
    if (sq_vld !== 1'b0 || ops_cnt !== exp_ops || err !== 1'b0) begin
      errors++; $display("FAIL basic_done: sq_vld=%b ops=%0d err=%b want 0 %0d 0", sq_vld, ops_cnt, err, exp_ops);
    end
    checks++;
    if (in_rdy !== 1'b0) begin
      errors++; $display("FAIL basic_gap: in_rdy=%b want 0", in_rdy);
    end
    @(negedge clk);
    checks++;
    if (in_rdy !== 1'b1 || sq_vld !== 1'b0) begin
      errors++; $display("FAIL basic_idle: in_rdy=%b sq_vld=%b want 1 0", in_rdy, sq_vld);
    end
  endtask

  task automatic test_stray_done();
    sq_done = 1'b1;
    repeat (3) @(negedge clk);
    sq_done = 1'b0;
    @(negedge clk);
    checks++;
    if (ops_cnt !== exp_ops || sq_vld !== 1'b0 || in_rdy !== 1'b1) begin
      errors++; $display("FAIL stray_done: ops=%0d sq_vld=%b in_rdy=%b want %0d 0 1", ops_cnt, sq_vld, in_rdy, exp_ops);
    end
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) begin
      int vi, vq, d, lat;
      logic [31:0] exp_x;
      bit stable;
      if (k == 0) begin vi = -32768; vq = -32768; end
      else if (k == 1) begin vi = -1; vq = 0; end
      else if (k == 2) begin vi = 32767; vq = -32768; end
      else begin vi = rand_s16(); vq = rand_s16(); end
      exp_x = model_sq(vi, vq);
      for (int w = 0; w < 10 && in_rdy !== 1'b1; w++) @(negedge clk);
      in_i = 16'(vi); in_q = 16'(vq); in_vld = 1'b1;
      @(negedge clk);
      in_vld = 1'b0; in_i = 16'($urandom); in_q = 16'($urandom);
      lat = 1;
      while (sq_vld !== 1'b1 && lat < 12) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat != 3) begin
        errors++; $display("FAIL rand_latency[%0d]: %0d cycles want 3", k, lat);
      end
      checks++;
      if (sq_x !== exp_x) begin
        errors++; $display("FAIL rand_sq_x[%0d]: i=%0d q=%0d got %h want %h", k, vi, vq, sq_x, exp_x);
      end
      d = int'($urandom_range(0, 20));
      stable = 1'b1;
      repeat (d) begin
        @(negedge clk);
        if (sq_vld !== 1'b1 || sq_x !== exp_x || err !== 1'b0) stable = 1'b0;
      end
      checks++;
      if (!stable) begin
        errors++; $display("FAIL rand_hold[%0d]: sq_vld=%b sq_x=%h err=%b want 1 %h 0", k, sq_vld, sq_x, err, exp_x);
      end
      sq_done = 1'b1;
      @(negedge clk);
      sq_done = 1'b0; exp_ops++;
      checks++;
      if (sq_vld !== 1'b0 || ops_cnt !== exp_ops) begin
        errors++; $display("FAIL rand_done[%0d]: sq_vld=%b ops=%0d want 0 %0d", k, sq_vld, ops_cnt, exp_ops);
      end
    end
  endtask

  task automatic test_timeout();
    int cnt;
    bit stable;
    for (int w = 0; w < 10 && in_rdy !== 1'b1; w++) @(negedge clk);
    in_i = 16'($urandom); in_q = 16'($urandom); in_vld = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    for (int w = 0; w < 10 && sq_vld !== 1'b1; w++) @(negedge clk);
    checks++;
    if (sq_vld !== 1'b1) begin
      errors++; $display("FAIL tmo_enter: sq_vld=%b want 1", sq_vld);
    end
    cnt = 0; stable = 1'b1;
    while (err !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (err !== 1'b1 && sq_vld !== 1'b1) stable = 1'b0;
    end
    checks++;
    if (cnt != TIMEOUT) begin
      errors++; $display("FAIL tmo_cycles: err after %0d cycles want %0d", cnt, TIMEOUT);
    end
    checks++;
    if (!stable) begin
      errors++; $display("FAIL tmo_vld_dropped: sq_vld fell before timeout, want held");
    end
    checks++;
    if (sq_vld !== 1'b0 || ops_cnt !== exp_ops || in_rdy !== 1'b0) begin
      errors++; $display("FAIL tmo_state: sq_vld=%b ops=%0d in_rdy=%b want 0 %0d 0", sq_vld, ops_cnt, in_rdy, exp_ops);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || in_rdy !== 1'b1) begin
      errors++; $display("FAIL tmo_after: err=%b in_rdy=%b want 0 1", err, in_rdy);
    end
  endtask

  task automatic test_done_at_timeout();
    for (int w = 0; w < 10 && in_rdy !== 1'b1; w++) @(negedge clk);
    in_i = 16'd5; in_q = 16'd12; in_vld = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    for (int w = 0; w < 10 && sq_vld !== 1'b1; w++) @(negedge clk);
    repeat (TIMEOUT - 1) @(negedge clk);
    checks++;
    if (sq_vld !== 1'b1 || err !== 1'b0 || sq_x !== 32'd169) begin
      errors++; $display("FAIL race_pre: sq_vld=%b err=%b sq_x=%0d want 1 0 169", sq_vld, err, sq_x);
    end
    sq_done = 1'b1;
    @(negedge clk);
    sq_done = 1'b0; exp_ops++;
    checks++;
    if (err !== 1'b0 || ops_cnt !== exp_ops || sq_vld !== 1'b0) begin
      errors++; $display("FAIL race_done_wins: err=%b ops=%0d sq_vld=%b want 0 %0d 0", err, ops_cnt, sq_vld, exp_ops);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL race_late_err: err=%b want 0", err);
    end
  endtask

  task automatic test_reset_mid();
    bit quiet;
    for (int w = 0; w < 10 && in_rdy !== 1'b1; w++) @(negedge clk);
    in_i = 16'd7; in_q = 16'd1; in_vld = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    for (int w = 0; w < 10 && sq_vld !== 1'b1; w++) @(negedge clk);
    checks++;
    if (sq_vld !== 1'b1) begin
      errors++; $display("FAIL rstmid_hold: sq_vld=%b want 1", sq_vld);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (sq_vld !== 1'b0 || in_rdy !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: sq_vld=%b in_rdy=%b want 0 0", sq_vld, in_rdy);
    end
    checks++;
    if (sq_x !== 32'd0 || ops_cnt !== 16'd0) begin
      errors++; $display("FAIL rstmid_data: sq_x=%h ops=%0d want 0 0", sq_x, ops_cnt);
    end
    exp_ops = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++; $display("FAIL rstmid_rdy: in_rdy=%b want 1", in_rdy);
    end
    // Reset while in MUL: the operation must vanish.
    in_i = 16'd9; in_q = 16'd9; in_vld = 1'b1;
    @(negedge clk);
    in_vld = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (sq_vld !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet || in_rdy !== 1'b1 || ops_cnt !== exp_ops) begin
      errors++; $display("FAIL rstmid_discard: quiet=%b in_rdy=%b ops=%0d want 1 1 %0d", quiet, in_rdy, ops_cnt, exp_ops);
    end
  endtask

  task automatic test_back_to_back();
    int vi[3];
    int vq[3];
    logic [31:0] expq[3];
    int sent, rises, cd, low_run, min_gap, bad_x;
    bit pend, prev;
    for (int k = 0; k < 3; k++) begin
      vi[k] = rand_s16(); vq[k] = rand_s16();
      expq[k] = model_sq(vi[k], vq[k]);
    end
    sent = 0; rises = 0; cd = 0; low_run = 0; min_gap = 1000; bad_x = 0; prev = 1'b0;
    for (int w = 0; w < 10 && in_rdy !== 1'b1; w++) @(negedge clk);
    in_i = 16'(vi[0]); in_q = 16'(vq[0]); in_vld = 1'b1;
    pend = (in_rdy === 1'b1);
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      sq_done = 1'b0;
      if (pend) begin
        sent++;
        if (sent < 3) begin
          in_i = 16'(vi[sent]); in_q = 16'(vq[sent]);
        end else begin
          in_vld = 1'b0;
        end
      end
      pend = in_vld && (in_rdy === 1'b1);
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          sq_done = 1'b1; exp_ops++;
        end
      end
      if (sq_vld === 1'b1 && !prev) begin
        if (rises > 0 && low_run < min_gap) min_gap = low_run;
        if (rises < 3 && sq_x !== expq[rises]) bad_x++;
        rises++; cd = 17;
      end
      if (sq_vld === 1'b1) low_run = 0; else low_run++;
      prev = (sq_vld === 1'b1);
    end
    sq_done = 1'b0; in_vld = 1'b0;
    checks++;
    if (sent != 3 || rises != 3) begin
      errors++; $display("FAIL b2b_count: accepted=%0d operands=%0d want 3 3", sent, rises);
    end
    checks++;
    if (bad_x != 0) begin
      errors++; $display("FAIL b2b_sq_x: %0d wrong operands want 0", bad_x);
    end
    checks++;
    if (min_gap < 1) begin
      errors++; $display("FAIL b2b_gap: min low gap %0d want >=1", min_gap);
    end
    checks++;
    if (ops_cnt !== exp_ops || exp_ops !== 16'd3) begin
      errors++; $display("FAIL b2b_ops: ops=%0d want 3 (model %0d)", ops_cnt, exp_ops);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stray_done();
    test_random(8);
    test_timeout();
    test_done_at_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
